// File: rtl/a25_wb_arbiter.sv
// Two-port Wishbone master arbiter: round-robin between 4-beat line fetches and
// single-beat data accesses, with bus-error reporting and a no-ack timeout.
module a25_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_fetch_req,
    input  logic [31:0]  i_fetch_address,
    output logic         o_fetch_ready,
    output logic [127:0] o_fetch_rdata,
    input  logic         i_data_req,
    input  logic         i_data_write,
    input  logic [31:0]  i_data_address,
    input  logic [31:0]  i_data_wdata,
    input  logic [3:0]   i_data_be,
    output logic         o_data_ready,
    output logic [31:0]  o_data_rdata,
    output logic         o_err,
    output logic [31:0]  o_wb_adr,
    output logic [3:0]   o_wb_sel,
    output logic         o_wb_we,
    output logic [31:0]  o_wb_dat,
    output logic         o_wb_cyc,
    output logic         o_wb_stb,
    input  logic [31:0]  i_wb_dat,
    input  logic         i_wb_ack,
    input  logic         i_wb_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [1:0]  beat;
    logic        last_fetch;
    logic [27:0] line_adr;
    logic [95:0] line_buf;
    logic [15:0] timer;
    logic        timeout_hit;
    logic        grant_fetch;
    logic        unused_addr_bits;

    assign timeout_hit      = (timer == TIMER_LAST);
    assign grant_fetch      = i_fetch_req && (!i_data_req || !last_fetch);
    assign unused_addr_bits = ^{i_fetch_address[3:0], i_data_address[1:0]};

    // Beats 0..2 collect in line_buf; the last beat is merged straight into the
    // output so o_fetch_rdata only changes on a completed line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            beat          <= '0;
            last_fetch    <= 1'b0;
            line_adr      <= '0;
            line_buf      <= '0;
            timer         <= '0;
            o_fetch_ready <= 1'b0;
            o_fetch_rdata <= '0;
            o_data_ready  <= 1'b0;
            o_data_rdata  <= '0;
            o_err         <= 1'b0;
            o_wb_adr      <= '0;
            o_wb_sel      <= '0;
            o_wb_we       <= 1'b0;
            o_wb_dat      <= '0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fetch) begin
                        state      <= FETCH;
                        last_fetch <= 1'b1;
                        line_adr   <= i_fetch_address[31:4];
                        beat       <= 2'd0;
                        timer      <= '0;
                        o_wb_adr   <= {i_fetch_address[31:4], 4'b0000};
                        o_wb_sel   <= 4'hF;
                        o_wb_we    <= 1'b0;
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                    end else if (i_data_req) begin
                        state      <= DATA;
                        last_fetch <= 1'b0;
                        timer      <= '0;
                        o_wb_adr   <= {i_data_address[31:2], 2'b00};
                        o_wb_sel   <= i_data_be;
                        o_wb_we    <= i_data_write;
                        o_wb_dat   <= i_data_wdata;
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (i_wb_err || (!i_wb_ack && timeout_hit)) begin
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                        o_fetch_ready <= 1'b1;
                        o_err         <= 1'b1;
                        state         <= RESP;
                    end else if (i_wb_ack) begin
                        timer <= '0;
                        if (beat == 2'd3) begin
                            o_wb_cyc      <= 1'b0;
                            o_wb_stb      <= 1'b0;
                            o_fetch_rdata <= {i_wb_dat, line_buf};
                            o_fetch_ready <= 1'b1;
                            state         <= RESP;
                        end else begin
                            case (beat)
                                2'd0:    line_buf[31:0]  <= i_wb_dat;
                                2'd1:    line_buf[63:32] <= i_wb_dat;
                                default: line_buf[95:64] <= i_wb_dat;
                            endcase
                            beat     <= beat + 2'd1;
                            o_wb_adr <= {line_adr, beat + 2'd1, 2'b00};
                        end
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DATA: begin
                    if (i_wb_err || (!i_wb_ack && timeout_hit)) begin
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_data_ready <= 1'b1;
                        o_err        <= 1'b1;
                        state        <= RESP;
                    end else if (i_wb_ack) begin
                        if (!o_wb_we) begin
                            o_data_rdata <= i_wb_dat;
                        end
                        o_wb_cyc     <= 1'b0;
                        o_wb_stb     <= 1'b0;
                        o_data_ready <= 1'b1;
                        state        <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                RESP: begin
                    o_fetch_ready <= 1'b0;
                    o_data_ready  <= 1'b0;
                    o_err         <= 1'b0;
                    beat          <= 2'd0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/a25_wb_arbiter.md
# a25_wb_arbiter

Two-port Wishbone master arbiter for the a25 core. It shares one 32-bit Wishbone bus between the instruction-fetch port and the data port. The fetch port issues 128-bit cache-line reads as 4-beat bursts; the data port issues single 32-bit reads or writes. The block sits between `a25_fetch` / the data cache and the system bus, and provides round-robin arbitration, beat sequencing, line assembly, bus-error reporting and a no-ack timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles `o_wb_stb` may stay high without ack/err before the transfer is aborted; legal range 1..65535.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_fetch_req` in 1: fetch line request, level; held until `o_fetch_ready`.
- `i_fetch_address` in 32: line address; bits [3:0] ignored.
- `o_fetch_ready` out 1: one-cycle completion pulse.
- `o_fetch_rdata` out 128: assembled line, valid while `o_fetch_ready` is high; beat k occupies [32k+31:32k].
- `i_data_req` in 1: data request, level; held until `o_data_ready`.
- `i_data_write` in 1: 1 = write, 0 = read.
- `i_data_address` in 32: word address; bits [1:0] driven as 0 on the bus.
- `i_data_wdata` in 32: write data.
- `i_data_be` in 4: byte enables.
- `o_data_ready` out 1: one-cycle completion pulse.
- `o_data_rdata` out 32: read data, valid with `o_data_ready`.
- `o_err` out 1: qualifies the current ready pulse; high means bus error or timeout.
- `o_wb_adr` out 32: Wishbone address.
- `o_wb_sel` out 4: byte selects.
- `o_wb_we` out 1: write enable.
- `o_wb_dat` out 32: write data.
- `o_wb_cyc` out 1: cycle.
- `o_wb_stb` out 1: strobe.
- `i_wb_dat` in 32: read data.
- `i_wb_ack` in 1: acknowledge.
- `i_wb_err` in 1: error.

## Operation
- States: IDLE, FETCH, DATA, RESP.
- **IDLE:** requests are sampled only in IDLE.
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last. The last-grant register resets to "data", so fetch wins the first tie.
  - On grant, register the address, write data, byte enables and write flag, then go to FETCH or DATA.
- **FETCH:**
  - Drive `o_wb_cyc`=`o_wb_stb`=1, `o_wb_we`=0, `o_wb_sel`=4'hF, and `o_wb_adr`={addr[31:4], beat[1:0], 2'b00}.
  - Beat counter runs 0..3.
  - On `i_wb_ack`, store `i_wb_dat` into lane `beat`. If beat=3, go to RESP; otherwise increment beat. `o_wb_stb` stays high between beats.
- **DATA:**
  - Drive a single beat: `o_wb_adr`={addr[31:2], 2'b00}, with `o_wb_sel`, `o_wb_we` and `o_wb_dat` taken from the registered request.
  - On ack, latch `i_wb_dat` (reads) and go to RESP.
- **Error:** `i_wb_err` in FETCH or DATA ends the transfer immediately (remaining beats skipped), sets the error flag and goes to RESP.
- **Timeout:** a counter is cleared on every ack and on grant, and increments each cycle stb is high. When it reaches `TIMEOUT_CYCLES`, go to RESP with the error flag set.
- **RESP:**
  - `o_wb_cyc`/`o_wb_stb` are low.
  - Pulse the granted port's ready for one cycle, with `o_err` = error flag.
  - Clear the flag and go to IDLE.
  - The requester must drop or replace its request in the cycle after ready; IDLE re-samples that cycle.
- **Ack and err together:** `i_wb_err` has priority over `i_wb_ack`.
- **Spurious inputs:** ack/err while `o_wb_stb` is low are ignored.
- **Request changes:** changes to request inputs after grant are ignored until the next IDLE.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; beat 0; last-grant = data; error flag 0.
- Reset asserted mid-transfer drops `o_wb_cyc`/`o_wb_stb` immediately (asynchronous reset) and issues no ready pulse.
- Request seen high at edge N gives `o_wb_cyc`/`o_wb_stb` high from edge N+1.
- Zero-wait slave (ack in same cycle as stb):
  - Fetch: acks at cycles N+1..N+4, `o_fetch_ready` at N+5 (5-cycle latency).
  - Data: ack at N+1, `o_data_ready` at N+2.
- Wait states add one cycle each.
- Minimum gap between consecutive grants: one IDLE cycle after RESP. `o_wb_cyc` is low for at least 2 cycles between transfers.
- `o_fetch_rdata` and `o_data_rdata` hold their values until the next completion on that port.

## Test plan
- **Single fetch:** fetch req, addr 0x0000_1238, zero-wait slave returning 0xA0+beat.
  - Bus addresses must be 0x1230, 0x1234, 0x1238, 0x123C.
  - `o_fetch_ready` at cycle 5 with rdata 0x000000A3_000000A2_000000A1_000000A0 and `o_err`=0.
- **Data write:** addr 0x40, wdata 0xDEADBEEF, be 4'b0011, slave with 2 wait states.
  - `o_wb_we`=1 and `o_wb_sel`=0011 held for 3 cycles.
  - `o_data_ready` 4 cycles after the request.
- **Simultaneous requests from reset:** fetch and data requested together and held continuously.
  - Grant order must be fetch, data, fetch, data.
- **Bus error:** `i_wb_err` on beat 2 of a fetch.
  - Exactly 3 beats issued; `o_fetch_ready`=1 with `o_err`=1 on the next cycle.
- **Timeout:** `TIMEOUT_CYCLES`=8, data read, slave never acks.
  - stb high for exactly 8 cycles; then `o_data_ready`=1 with `o_err`=1.
  - A following fetch completes normally.
- **Reset mid-burst:** assert `reset`=0 during beat 1.
  - `o_wb_cyc`=0 without waiting for a clock edge; no ready pulse.
  - After release, a new fetch starts at beat 0.
